// File: rtl/dvi_pixel_capture.sv
// DVI DDR pixel capture: frame sync, pixel coordinates and a
// first-word-fall-through output FIFO with frame size measurement.
module dvi_pixel_capture #(
  parameter int   FIFO_DEPTH = 16,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic        fbclk,
  input  logic        fbclk_rst_b,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [11:0] in_d_rise,
  input  logic [11:0] in_d_fall,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [11:0] frame_width,
  output logic [11:0] frame_height,
  output logic        frame_done,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {SEEK, IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [23:0] pix;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
  } ent_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic        de_q, hs_q, vs_q, de_p, vsa_p;
  logic [11:0] rise_q, fall_q;
  logic        vs_a, vs_lead, de_rise, de_fall;
  logic        unused_hs;

  assign vs_a      = (vs_q == SYNC_POL);
  assign vs_lead   = vs_a && !vsa_p;
  assign de_rise   = de_q && !de_p;
  assign de_fall   = !de_q && de_p;
  assign unused_hs = hs_q;

  always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      de_q   <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      rise_q <= '0;
      fall_q <= '0;
      de_p   <= 1'b0;
      vsa_p  <= 1'b0;
    end else begin
      de_q   <= in_de;
      hs_q   <= in_hs;
      vs_q   <= in_vs;
      rise_q <= in_d_rise;
      fall_q <= in_d_fall;
      de_p   <= de_q;
      vsa_p  <= vs_a;
    end
  end

  state_t      state, state_n;
  logic [11:0] x_cnt, y_cnt, width_q, cur_x;
  logic        accept, synced;

  assign synced = (state != SEEK);
  assign cur_x  = de_rise ? 12'd0 : x_cnt;
  assign accept = de_q && !vs_lead &&
                  ((state == ACTIVE) ||
                   (state == IDLE && de_rise));

  always_comb begin
    state_n = state;
    unique case (state)
      SEEK:    if (vs_lead) state_n = IDLE;
      IDLE: begin
        if (vs_lead)      state_n = IDLE;
        else if (de_rise) state_n = ACTIVE;
      end
      ACTIVE:  if (vs_lead || de_fall) state_n = IDLE;
      default: state_n = SEEK;
    endcase
  end

  logic        pk_v, pk_sof;
  logic [23:0] pk_pix;
  logic [11:0] pk_x, pk_y;

  always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      state        <= SEEK;
      x_cnt        <= '0;
      y_cnt        <= '0;
      width_q      <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
      pk_v         <= 1'b0;
      pk_pix       <= '0;
      pk_x         <= '0;
      pk_y         <= '0;
      pk_sof       <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= 1'b0;
      if (accept) x_cnt <= sat_inc(cur_x);
      if (vs_lead) begin
        y_cnt <= '0;
        if (synced && y_cnt != 12'd0) begin
          frame_width  <= width_q;
          frame_height <= y_cnt;
          frame_done   <= 1'b1;
        end
      end else if (state == ACTIVE && de_fall) begin
        y_cnt   <= sat_inc(y_cnt);
        width_q <= x_cnt;
      end
      pk_v   <= accept;
      pk_pix <= {fall_q, rise_q};
      pk_x   <= cur_x;
      pk_y   <= y_cnt;
      pk_sof <= (cur_x == 12'd0) && (y_cnt == 12'd0);
    end
  end

  // eol looks one registered sample ahead of the packed pixel
  ent_t        mem [FIFO_DEPTH];
  ent_t        wr_e, rd_e;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        pop, full, drop, wr_en;

  assign wr_e  = '{pix: pk_pix, x: pk_x, y: pk_y,
                   sof: pk_sof, eol: !de_q || vs_lead};
  assign full  = (wr_ptr - rd_ptr) == FULL_CNT;
  assign pop   = pix_valid && pix_ready;
  assign drop  = pk_v && full && !pop;
  assign wr_en = pk_v && !drop;

  always_ff @(posedge fbclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_e;
  end

  always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign rd_e      = mem[rd_ptr[AW-1:0]];
  assign pix_valid = (wr_ptr != rd_ptr);
  assign pix_data  = pix_valid ? rd_e.pix : '0;
  assign pix_x     = pix_valid ? rd_e.x   : '0;
  assign pix_y     = pix_valid ? rd_e.y   : '0;
  assign pix_sof   = pix_valid && rd_e.sof;
  assign pix_eol   = pix_valid && rd_e.eol;

endmodule

// File: tb/tb_dvi_pixel_capture.sv
// Directed bench for dvi_pixel_capture: vector table plus
// scoreboarded line/frame sequences.
module tb_dvi_pixel_capture;

  logic        fbclk = 1'b0;
  logic        fbclk_rst_b = 1'b0;
  logic        in_de = 1'b0, in_hs = 1'b1, in_vs = 1'b1;
  logic [11:0] in_d_rise = '0, in_d_fall = '0;
  logic        pix_ready = 1'b0, ovf_clr = 1'b0;
  logic        pix_valid, pix_sof, pix_eol;
  logic [23:0] pix_data;
  logic [11:0] pix_x, pix_y, frame_width, frame_height;
  logic        frame_done, overflow;

  dvi_pixel_capture #(.FIFO_DEPTH(16), .SYNC_POL(1'b0)) dut (
    .fbclk(fbclk), .fbclk_rst_b(fbclk_rst_b),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_d_rise(in_d_rise), .in_d_fall(in_d_fall),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_width(frame_width), .frame_height(frame_height),
    .frame_done(frame_done),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 fbclk = ~fbclk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] d;
    logic [11:0] x, y;
    logic        sof, eol;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 0, rnd_rdy = 0;
  int   fd_cnt = 0, v_cnt = 0;

  always @(negedge fbclk) begin
    exp_t e;
    if (fbclk_rst_b && frame_done) fd_cnt++;
    if (pix_valid) v_cnt++;
    if (mon_en && pix_valid && pix_ready) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 64'(pix_x), 64'hFFFF);
      end else begin
        e = q.pop_front();
        chk("pop_entry",
            64'({pix_data, pix_x, pix_y, pix_sof, pix_eol}),
            64'({e.d, e.x, e.y, e.sof, e.eol}));
      end
    end
  end

  always @(posedge fbclk) begin
    #1;
    if (rnd_rdy) pix_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge fbclk);
    #1;
  endtask

  task automatic drive(input logic de, input logic vs,
                       input logic [11:0] r, input logic [11:0] f);
    in_de = de;
    in_vs = vs;
    in_hs = ~de;
    in_d_rise = r;
    in_d_fall = f;
  endtask

  function automatic logic [11:0] prise(int x, int y);
    return 12'(x * 16 + y);
  endfunction

  function automatic logic [11:0] pfall(int x, int y);
    return 12'(12'h800 + y * 64 + x);
  endfunction

  task automatic vsync();
    drive(0, 0, 0, 0);
    step();
    drive(0, 1, 0, 0);
    step();
    step();
  endtask

  task automatic line(input int n, input int y, input int keep);
    exp_t e;
    for (int x = 0; x < n; x++) begin
      drive(1, 1, prise(x, y), pfall(x, y));
      if (x < keep) begin
        e.d = {pfall(x, y), prise(x, y)};
        e.x = 12'(x);
        e.y = 12'(y);
        e.sof = (x == 0) && (y == 0);
        e.eol = (x == n - 1);
        q.push_back(e);
      end
      step();
    end
    drive(0, 1, 0, 0);
    repeat (3) step();
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      step();
      t++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  typedef struct {
    logic        de, vs, rdy;
    logic [11:0] r, f;
    logic        ev;
    logic [49:0] ent;
  } vec_t;

  vec_t vt[9];
  int   fd0, v0;

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 12'h0,   12'h0,   1'b0, 50'd0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 12'h0,   12'h0,   1'b0, 50'd0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 12'h0,   12'h0,   1'b0, 50'd0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 12'h5A5, 12'hC3F, 1'b0, 50'd0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 12'h0,   12'h0,   1'b0, 50'd0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 12'h0,   12'h0,   1'b1,
              {24'hC3F5A5, 12'd0, 12'd0, 1'b1, 1'b1}};
    vt[6] = '{1'b0, 1'b1, 1'b0, 12'h0,   12'h0,   1'b1,
              {24'hC3F5A5, 12'd0, 12'd0, 1'b1, 1'b1}};
    vt[7] = '{1'b0, 1'b1, 1'b1, 12'h0,   12'h0,   1'b0, 50'd0};
    vt[8] = '{1'b0, 1'b1, 1'b0, 12'h0,   12'h0,   1'b0, 50'd0};

    repeat (2) step();
    chk("rst_pix", 64'({pix_valid, pix_sof, pix_eol, pix_data,
                        pix_x, pix_y}), 64'd0);
    chk("rst_frame", 64'({frame_width, frame_height, frame_done,
                          overflow}), 64'd0);
    fbclk_rst_b = 1'b1;
    repeat (2) step();

    // single pixel after vsync, latency and hold under backpressure
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].de, vt[i].vs, vt[i].r, vt[i].f);
      pix_ready = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(pix_valid), 64'(vt[i].ev));
      if (vt[i].ev)
        chk($sformatf("vec%0d_entry", i),
            64'({pix_data, pix_x, pix_y, pix_sof, pix_eol}),
            64'(vt[i].ent));
    end

    fd0 = fd_cnt;
    vsync();
    step();
    chk("f1_done", 64'(fd_cnt - fd0), 64'd1);
    chk("f1_size", 64'({frame_width, frame_height}), {40'd0, 12'd1, 12'd1});

    // 4 lines of 8 pixels
    mon_en = 1;
    pix_ready = 1'b1;
    fd0 = fd_cnt;
    for (int y = 0; y < 4; y++) line(8, y, 8);
    drain();
    chk("f2_nodone_yet", 64'(fd_cnt - fd0), 64'd0);
    vsync();
    step();
    chk("f2_done", 64'(fd_cnt - fd0), 64'd1);
    chk("f2_width", 64'(frame_width), 64'd8);
    chk("f2_height", 64'(frame_height), 64'd4);

    // empty frame leaves frame size alone
    fd0 = fd_cnt;
    vsync();
    repeat (2) step();
    chk("f3_empty_done", 64'(fd_cnt - fd0), 64'd0);
    chk("f3_size", 64'({frame_width, frame_height}), {40'd0, 12'd8, 12'd4});

    // random backpressure without filling the FIFO
    rnd_rdy = 1;
    for (int y = 0; y < 6; y++) begin
      line(8, y, 8);
      drain();
    end
    rnd_rdy = 0;
    step();
    pix_ready = 1'b0;
    chk("rnd_no_ovf", 64'(overflow), 64'd0);

    // overflow: 20 pixels into a 16-deep FIFO
    vsync();
    pix_ready = 1'b0;
    line(20, 0, 16);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_valid", 64'(pix_valid), 64'd1);
    pix_ready = 1'b1;
    drain();
    step();
    chk("ovf_empty", 64'(pix_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // activity before first vsync is discarded
    mon_en = 0;
    pix_ready = 1'b0;
    q.delete();
    fbclk_rst_b = 1'b0;
    step();
    fbclk_rst_b = 1'b1;
    fd0 = fd_cnt;
    v0 = v_cnt;
    line(5, 0, 0);
    line(5, 1, 0);
    repeat (4) step();
    chk("seek_valid", 64'(v_cnt - v0), 64'd0);
    chk("seek_done", 64'(fd_cnt - fd0), 64'd0);
    q.delete();

    // reset mid-line with entries buffered
    vsync();
    for (int x = 0; x < 5; x++) begin
      drive(1, 1, prise(x, 0), pfall(x, 0));
      step();
    end
    drive(1, 1, prise(5, 0), pfall(5, 0));
    chk("mid_buffered", 64'(pix_valid), 64'd1);
    #2;
    fbclk_rst_b = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(pix_valid), 64'd0);
    step();
    step();
    fbclk_rst_b = 1'b1;
    v0 = v_cnt;
    for (int x = 6; x < 10; x++) begin
      drive(1, 1, prise(x, 0), pfall(x, 0));
      step();
    end
    drive(0, 1, 0, 0);
    repeat (5) step();
    chk("post_rst_quiet", 64'(v_cnt - v0), 64'd0);
    vsync();
    drive(1, 1, 12'h123, 12'h456);
    step();
    drive(0, 1, 0, 0);
    step();
    step();
    chk("resync_entry",
        64'({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol}),
        64'({1'b1, 24'h456123, 12'd0, 12'd0, 1'b1, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_pixel_capture.md
DVI_PIXEL_CAPTURE -- requirements
Module: dvi_pixel_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning the output FIFO depth in pixels (power of 2, 4..64).
REQ-002 SHALL have parameter SYNC_POL, default 1'b0, meaning the active level of in_vs and in_hs (0 = active-low).
REQ-003 SHALL have port fbclk  input  1  pixel clock; all logic is on its rising edge.
REQ-004 SHALL have port fbclk_rst_b  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_de, in_hs, in_vs  input  1 each  data-enable, hsync and vsync sampled from the DVI bus.
REQ-006 SHALL have port in_d_rise  input  12  DDR bus half captured on the rising edge, = {green[3:0], blue[7:0]}.
REQ-007 SHALL have port in_d_fall  input  12  DDR bus half captured on the falling edge, = {red[7:0], green[7:4]}, aligned to the same fbclk cycle as in_d_rise.
REQ-008 SHALL have ports pix_valid  output  1  and pix_ready  input  1  forming the pixel stream handshake.
REQ-009 SHALL have port pix_data  output  24  pixel as {red, green, blue}.
REQ-010 SHALL have ports pix_x, pix_y  output  12 each  pixel coordinates.
REQ-011 SHALL have ports pix_sof, pix_eol  output  1 each  first pixel of frame, last pixel of line; both travel with pix_data.
REQ-012 SHALL have ports frame_width, frame_height  output  12 each  measured active size of the last complete frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when frame_width and frame_height update.
REQ-014 SHALL have ports overflow  output  1  sticky drop flag, and ovf_clr  input  1  which clears it.

Function
REQ-015 SHALL register in_de/in_hs/in_vs/in_d_rise/in_d_fall in one input stage; all edge detection uses the registered copies.
REQ-016 SHALL have states SEEK (discard all input until the vsync leading edge), IDLE (synced, de low) and ACTIVE (de high).
REQ-017 SHALL go SEEK->IDLE on vsync leading edge, IDLE->ACTIVE on de rising, ACTIVE->IDLE on de falling; vsync leading edge in ACTIVE SHALL go to IDLE and end the line.
REQ-018 SHALL reset x to 0 at each de rising edge and increment it per accepted de-high cycle, saturating at 4095.
REQ-019 SHALL reset y to 0 on the vsync leading edge and increment it at each de falling edge, saturating at 4095.
REQ-020 SHALL write one FIFO entry per de-high cycle in IDLE/ACTIVE; each entry is {pixel, x, y, sof, eol}.
REQ-021 SHALL set sof when x=0 and y=0; SHALL set eol on the entry whose next registered in_de is low, which requires one stage of look-ahead.
REQ-022 SHALL give 3 cycles of latency from an input sample to pix_valid when the FIFO is empty: input register, pack stage, then FWFT output.
REQ-023 SHALL pop the FIFO on pix_valid && pix_ready; pix_data/x/y/sof/eol SHALL hold stable while pix_valid && !pix_ready.
REQ-024 SHALL, when the FIFO is full and a write arrives with no pop in the same cycle, drop that pixel only and set overflow.
REQ-025 SHALL accept a write when the FIFO is full and a pop occurs in the same cycle (no drop).
REQ-026 SHALL read and write simultaneously without change in occupancy; an empty FIFO SHALL never assert pix_valid.
REQ-027 SHALL clear overflow when ovf_clr is high unless a new drop occurs in the same cycle, in which case set wins.
REQ-028 SHALL latch the last line's x count into a width register at each de falling edge.
REQ-029 SHALL, at the vsync leading edge in IDLE/ACTIVE with y>0, copy the width register to frame_width and y to frame_height and pulse frame_done; frames with y=0 SHALL NOT update either or pulse.
REQ-030 SHALL NOT use in_hs for timing; it is registered for alignment only.

Reset
REQ-031 SHALL, on fbclk_rst_b low, asynchronously clear state to SEEK, FIFO pointers to empty, x=y=0, and set pix_valid=0, pix_sof=0, pix_eol=0, pix_data=0, pix_x=0, pix_y=0, frame_width=0, frame_height=0, frame_done=0, overflow=0.
REQ-032 SHALL, on reset mid-line, discard all buffered pixels and resume output only after the next vsync leading edge.

Verification
REQ-033 SHALL cover: in_d_rise=12'h5A5, in_d_fall=12'hC3F, one pixel after vsync -> pix_data=24'hC3F5A5, x=0, y=0, sof=1, eol=1, 3 cycles after the sample.
REQ-034 SHALL cover: 4 lines of 8 pixels, then vsync -> frame_width=8, frame_height=4, one frame_done pulse; eol set exactly at x=7.
REQ-035 SHALL cover: pix_ready=0, FIFO_DEPTH=16, a 20-pixel line -> 16 stored, pixels x=16..19 dropped, overflow=1; ovf_clr -> overflow=0.
REQ-036 SHALL cover: de activity before the first vsync -> no pix_valid, no frame_done.
REQ-037 SHALL cover: reset asserted at x=5 with 3 entries buffered -> pix_valid=0 immediately; no output until after the next vsync.
REQ-038 SHALL cover: random pix_ready backpressure with the FIFO never full -> output sequence identical to input, no overflow.
